// File: rtl/conv1d_mac_ctrl.sv
// 1-D convolution engine: loop FSM, X/Y address generation, signed MAC, Z writeback.
// Build option: define CONV_SATURATE_EN to clamp z_data instead of wrapping it.
module conv1d_mac_ctrl #(
    parameter int DW = 8,
    parameter int AW = 5,
    parameter int ZW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] size_x,
    input  logic [AW-1:0] size_y,
    input  logic          mode,
    output logic [AW-1:0] x_addr,
    output logic [AW-1:0] y_addr,
    input  logic [DW-1:0] x_data,
    input  logic [DW-1:0] y_data,
    output logic [AW:0]   z_addr,
    output logic [ZW-1:0] z_data,
    output logic          z_we,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int ACC_W = 2*DW + AW;
    localparam int KW    = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_SETK, S_ISSUE, S_DRAIN, S_WRITE, S_DONE
    } state_t;

    state_t state, nxt;

    logic [KW-1:0] sx, sy, k, k_start, k_end;
    logic [AW-1:0] j, j_hi, last_x, last_y;
    logic          md, v;
    logic signed [ACC_W-1:0] acc;

    logic [KW-1:0] ks_c, ke_c, k1, j_lo_c, j_hi_c, ky;
    logic          bad;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext;

    assign bad  = (sx == '0) || (sy == '0) || (md && (sx < sy));
    assign ks_c = md ? sy - KW'(1) : '0;
    assign ke_c = md ? sx - KW'(1) : sx + sy - KW'(2);

    // window of j that keeps both k-j and j inside their operands
    assign k1     = k + KW'(1);
    assign j_lo_c = (k1 > sy) ? k1 - sy : '0;
    assign j_hi_c = (k < sx - KW'(1)) ? k : sx - KW'(1);
    assign ky     = k - {1'b0, j};

    assign prod     = $signed(x_data) * $signed(y_data);
    assign prod_ext = {{AW{prod[2*DW-1]}}, prod};

    logic unused_bits;
    assign unused_bits = ^{j_lo_c[AW], j_hi_c[AW], ky[AW]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE:  if (start) nxt = S_INIT;
            S_INIT:  nxt = bad ? S_DONE : S_SETK;
            S_SETK:  nxt = S_ISSUE;
            S_ISSUE: if (j == j_hi) nxt = S_DRAIN;
            S_DRAIN: nxt = S_WRITE;
            S_WRITE: nxt = (k == k_end) ? S_DONE : S_SETK;
            S_DONE:  nxt = S_IDLE;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sx      <= '0;
            sy      <= '0;
            md      <= 1'b0;
            k       <= '0;
            k_start <= '0;
            k_end   <= '0;
            j       <= '0;
            j_hi    <= '0;
            last_x  <= '0;
            last_y  <= '0;
            v       <= 1'b0;
            acc     <= '0;
            err     <= 1'b0;
        end else begin
            // product of the address issued last cycle lands now
            v <= (state == S_ISSUE);
            if (v) acc <= acc + prod_ext;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        sx  <= {1'b0, size_x};
                        sy  <= {1'b0, size_y};
                        md  <= mode;
                        err <= 1'b0;
                    end
                end
                S_INIT: begin
                    if (bad) begin
                        err <= 1'b1;
                    end else begin
                        k       <= ks_c;
                        k_start <= ks_c;
                        k_end   <= ke_c;
                    end
                end
                S_SETK: begin
                    j    <= j_lo_c[AW-1:0];
                    j_hi <= j_hi_c[AW-1:0];
                    acc  <= '0;
                end
                S_ISSUE: begin
                    j      <= j + AW'(1);
                    last_x <= j;
                    last_y <= ky[AW-1:0];
                end
                S_WRITE: begin
                    if (k != k_end) k <= k + KW'(1);
                end
                default: ;
            endcase
        end
    end

    assign x_addr = (state == S_ISSUE) ? j : last_x;
    assign y_addr = (state == S_ISSUE) ? ky[AW-1:0] : last_y;
    assign z_addr = k - k_start;
    assign z_we   = (state == S_WRITE);
    assign done   = (state == S_DONE);
    assign busy   = (state != S_IDLE) && (state != S_DONE);

`ifdef CONV_SATURATE_EN
    localparam logic signed [ACC_W-1:0] ZMAX =
        {{(ACC_W-ZW+1){1'b0}}, {(ZW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ZMIN =
        {{(ACC_W-ZW+1){1'b1}}, {(ZW-1){1'b0}}};

    always_comb begin
        z_data = acc[ZW-1:0];
        if (acc > ZMAX)      z_data = ZMAX[ZW-1:0];
        else if (acc < ZMIN) z_data = ZMIN[ZW-1:0];
    end
`else
    assign z_data = acc[ZW-1:0];
`endif

endmodule
